cache_l3_responder: RTL and testbench

//  L3 side of the L2<->L3 protocol. Services L2 block reads (read_from_L3_request -> L3_ready)
//  and dirty write-backs (write_back_to_L3_request -> write_back_to_L2_verified).

---
 rtl/cache_config_pkg.sv | 27 ++
 rtl/cache_l3_responder_line_store.sv | 47 ++++
 rtl/cache_l3_responder.sv | 189 ++++++++++++++++++
 tb/tb_cache_l3_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_config_pkg.sv
// Shared types and geometry for the L3 responder: state encoding, line layout, address split.
package cache_config;
  localparam int L3_ADDRESS_WIDTH = 32;
  localparam int L3_BLOCK_WIDTH   = 128;
  localparam int L3_NUM_SETS      = 64;
  localparam int L3_OFFSET_BITS   = 4;
  localparam int L3_INDEX_WIDTH   = $clog2(L3_NUM_SETS);
  // Top two address bits carry the processor id and never reach the tag.
  localparam int L3_TAG_WIDTH     = L3_ADDRESS_WIDTH - 2 - L3_INDEX_WIDTH - L3_OFFSET_BITS;
  localparam int L3_TAG_LSB       = L3_OFFSET_BITS + L3_INDEX_WIDTH;

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, RESPOND, RELEASE} l3_state_t;

  typedef struct packed {
    logic                      valid;
    logic                      dirty;
    logic [L3_TAG_WIDTH-1:0]   tag;
    logic [L3_BLOCK_WIDTH-1:0] data;
  } l3_line_t;

  function automatic logic [L3_ADDRESS_WIDTH-1:0] l3_block_addr(
    input logic [L3_TAG_WIDTH-1:0]   tag,
    input logic [L3_INDEX_WIDTH-1:0] idx
  );
    return {2'b00, tag, idx, {L3_OFFSET_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/cache_l3_responder_line_store.sv
// Direct-mapped L3 line array: async read by index, one sync write port, dirty clear.
module l3_line_store
  import cache_config::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [L3_INDEX_WIDTH-1:0] idx,
  output l3_line_t                  line,
  input  logic                      wr_en,
  input  l3_line_t                  wr_line,
  input  logic                      clr_dirty
);
  logic [L3_NUM_SETS-1:0]    valid_q, valid_d, dirty_q, dirty_d;
  logic [L3_TAG_WIDTH-1:0]   tag_q  [L3_NUM_SETS];
  logic [L3_BLOCK_WIDTH-1:0] data_q [L3_NUM_SETS];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en) begin
      valid_d[idx] = wr_line.valid;
      dirty_d[idx] = wr_line.dirty;
    end else if (clr_dirty) begin
      dirty_d[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data carry no reset; the valid bit gates them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[idx]  <= wr_line.tag;
      data_q[idx] <= wr_line.data;
    end
  end

  assign line = '{valid: valid_q[idx], dirty: dirty_q[idx], tag: tag_q[idx], data: data_q[idx]};
endmodule

// File: rtl/cache_l3_responder.sv
// L3 responder for L2 block reads and dirty write-backs; direct-mapped, write-back, memory backed.
// Optional L3_STATS_EN enables saturating hit/miss counters (ports are tied to 0 otherwise).
module cache_l3_responder
  import cache_config::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        read_from_L3_request,
  input  logic                        write_back_to_L3_request,
  input  logic [L3_ADDRESS_WIDTH-1:0] cache_L3_memory_address,
  input  logic [L3_BLOCK_WIDTH-1:0]   L2_writeback_data,
  output logic                        L3_ready,
  output logic [L3_BLOCK_WIDTH-1:0]   L3_read_data,
  output logic                        write_back_to_L2_verified,
  output logic                        L3_hit,
  output logic                        L3_miss,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [L3_ADDRESS_WIDTH-1:0] mem_addr,
  output logic [L3_BLOCK_WIDTH-1:0]   mem_wdata,
  input  logic                        mem_ack,
  input  logic [L3_BLOCK_WIDTH-1:0]   mem_rdata,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
);
  l3_state_t                 state_q, state_d;
  logic                      req_wb_q, req_wb_d, relookup_q, relookup_d;
  logic                      ready_q, ready_d, verified_q, verified_d;
  logic [L3_BLOCK_WIDTH-1:0] rdata_q, rdata_d, wb_data_q, wb_data_d;
  logic [L3_TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [L3_INDEX_WIDTH-1:0] idx_q, idx_d;
  l3_line_t                  line, wr_line;
  logic                      wr_en, clr_dirty, hit, victim_dirty;
  logic                      unused_addr_bits;

  assign unused_addr_bits = ^{cache_L3_memory_address[L3_ADDRESS_WIDTH-1 -: 2],
                              cache_L3_memory_address[L3_OFFSET_BITS-1:0]};

  l3_line_store u_store (
    .clk      (clk),
    .reset    (reset),
    .idx      (idx_q),
    .line     (line),
    .wr_en    (wr_en),
    .wr_line  (wr_line),
    .clr_dirty(clr_dirty)
  );

  assign hit          = line.valid && (line.tag == tag_q);
  assign victim_dirty = line.valid && line.dirty && !hit;

  always_comb begin
    state_d    = state_q;
    req_wb_d   = req_wb_q;
    relookup_d = relookup_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    wb_data_d  = wb_data_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    verified_d = 1'b0;
    wr_en      = 1'b0;
    wr_line    = '0;
    clr_dirty  = 1'b0;
    L3_hit     = 1'b0;
    L3_miss    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        if (write_back_to_L3_request || read_from_L3_request) begin
          req_wb_d   = write_back_to_L3_request;
          tag_d      = cache_L3_memory_address[L3_ADDRESS_WIDTH-3:L3_TAG_LSB];
          idx_d      = cache_L3_memory_address[L3_OFFSET_BITS +: L3_INDEX_WIDTH];
          wb_data_d  = L2_writeback_data;
          relookup_d = 1'b0;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        // The lookup repeated after a write-back eviction is not a new access.
        L3_hit  = hit && !relookup_q;
        L3_miss = !hit && !relookup_q;
        if (victim_dirty) begin
          state_d = EVICT;
        end else if (req_wb_q) begin
          wr_en      = 1'b1;
          wr_line    = '{valid: 1'b1, dirty: 1'b1, tag: tag_q, data: wb_data_q};
          verified_d = 1'b1;
          state_d    = RESPOND;
        end else if (hit) begin
          ready_d = 1'b1;
          rdata_d = line.data;
          state_d = RESPOND;
        end else begin
          state_d = FILL;
        end
      end
      EVICT: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = l3_block_addr(line.tag, idx_q);
        mem_wdata = line.data;
        if (mem_ack) begin
          clr_dirty = 1'b1;
          if (req_wb_q) begin
            relookup_d = 1'b1;
            state_d    = LOOKUP;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = l3_block_addr(tag_q, idx_q);
        if (mem_ack) begin
          wr_en   = 1'b1;
          wr_line = '{valid: 1'b1, dirty: 1'b0, tag: tag_q, data: mem_rdata};
          ready_d = 1'b1;
          rdata_d = mem_rdata;
          state_d = RESPOND;
        end
      end
      RESPOND: state_d = RELEASE;
      RELEASE: begin
        if (!read_from_L3_request && !write_back_to_L3_request) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_wb_q   <= 1'b0;
      relookup_q <= 1'b0;
      ready_q    <= 1'b0;
      verified_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_wb_q   <= req_wb_d;
      relookup_q <= relookup_d;
      ready_q    <= ready_d;
      verified_q <= verified_d;
      rdata_q    <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q     <= tag_d;
    idx_q     <= idx_d;
    wb_data_q <= wb_data_d;
  end

  assign L3_ready                  = ready_q;
  assign write_back_to_L2_verified = verified_q;
  assign L3_read_data              = rdata_q;

`ifdef L3_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (L3_hit && (hit_count_q != '1))   hit_count_d  = hit_count_q + 32'd1;
    if (L3_miss && (miss_count_q != '1)) miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_cache_l3_responder.sv
// Bench for cache_l3_responder: vector table of L2 transactions with a memory responder,
// plus hand sequences for simultaneous requests, held requests and reset mid-fill.
module tb_cache_l3_responder;
  logic         clk = 1'b0;
  logic         reset;
  logic         read_from_L3_request, write_back_to_L3_request;
  logic [31:0]  cache_L3_memory_address;
  logic [127:0] L2_writeback_data;
  logic         L3_ready, write_back_to_L2_verified, L3_hit, L3_miss;
  logic [127:0] L3_read_data;
  logic         mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic [31:0]  hit_count, miss_count;

  always #5 clk = ~clk;

  cache_l3_responder dut (
    .clk                      (clk),
    .reset                    (reset),
    .read_from_L3_request     (read_from_L3_request),
    .write_back_to_L3_request (write_back_to_L3_request),
    .cache_L3_memory_address  (cache_L3_memory_address),
    .L2_writeback_data        (L2_writeback_data),
    .L3_ready                 (L3_ready),
    .L3_read_data             (L3_read_data),
    .write_back_to_L2_verified(write_back_to_L2_verified),
    .L3_hit                   (L3_hit),
    .L3_miss                  (L3_miss),
    .mem_req                  (mem_req),
    .mem_we                   (mem_we),
    .mem_addr                 (mem_addr),
    .mem_wdata                (mem_wdata),
    .mem_ack                  (mem_ack),
    .mem_rdata                (mem_rdata),
    .hit_count                (hit_count),
    .miss_count               (miss_count)
  );

  typedef struct { bit we; logic [31:0] addr; logic [127:0] data; } mem_op_t;
  typedef struct { bit wb; logic [127:0] data; } resp_t;
  typedef struct {
    string name; bit wb; logic [31:0] addr; logic [127:0] wd; bit hit;
    logic [127:0] rdata; int lat; int nmem; mem_op_t m0; mem_op_t m1;
  } vec_t;

  mem_op_t memq[$];
  resp_t   sbq[$];
  vec_t    vecs[8];
  int total = 0, bad = 0;
  int exp_hits = 0, exp_misses = 0;

  localparam logic [127:0] D_A5   = {16{8'hA5}};
  localparam logic [127:0] D_1234 = {8{16'h1234}};
  localparam logic [127:0] D_5A   = {16{8'h5A}};
  localparam logic [127:0] D_C3   = {16{8'hC3}};
  localparam logic [127:0] D_DEAD = {8{16'hDEAD}};
  localparam logic [127:0] D_BEEF = {8{16'hBEEF}};
  localparam logic [127:0] D_7777 = {8{16'h7777}};
  localparam logic [127:0] D_66   = {16{8'h66}};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input string n, input bit wb, input logic [31:0] a,
                               input logic [127:0] wd, input bit hit, input logic [127:0] rd,
                               input int lat, input int nmem, input bit w0, input logic [31:0] a0,
                               input logic [127:0] d0, input bit w1, input logic [31:0] a1,
                               input logic [127:0] d1);
    vec_t v;
    v.name = n; v.wb = wb; v.addr = a; v.wd = wd; v.hit = hit; v.rdata = rd;
    v.lat = lat; v.nmem = nmem;
    v.m0 = '{we: w0, addr: a0, data: d0};
    v.m1 = '{we: w1, addr: a1, data: d1};
    return v;
  endfunction

  // Memory responder: checks the request against the next expected op and acks it.
  task automatic service_mem(input string name);
    mem_op_t op;
    if (memq.size() == 0) begin
      total++; bad++;
      $display("FAIL %s mem: unexpected mem_req we=%0b addr=%0h, required none", name, mem_we, mem_addr);
      mem_rdata = '0;
      mem_ack   = 1'b1;
      return;
    end
    op = memq.pop_front();
    check({name, " mem_we"}, 128'(mem_we), 128'(op.we));
    check({name, " mem_addr"}, 128'(mem_addr), 128'(op.addr));
    if (op.we) check({name, " mem_wdata"}, mem_wdata, op.data);
    mem_rdata = op.we ? '0 : op.data;
    mem_ack   = 1'b1;
  endtask

  task automatic run_txn(input string name, input bit wb, input logic [31:0] addr,
                         input logic [127:0] wd, input bit exp_hit, input logic [127:0] exp_data,
                         input int exp_lat);
    int hc = 0, mc = 0, lat = 0;
    bit done = 0;
    resp_t r;
    sbq.push_back('{wb: wb, data: exp_data});
    if (exp_hit) exp_hits++; else exp_misses++;
    @(negedge clk);
    cache_L3_memory_address  = addr;
    L2_writeback_data        = wd;
    write_back_to_L3_request = wb;
    read_from_L3_request     = !wb;
    for (int i = 1; i <= 200 && !done; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      hc += int'(L3_hit);
      mc += int'(L3_miss);
      if (mem_req) service_mem(name);
      if (L3_ready || write_back_to_L2_verified) begin
        lat  = i;
        done = 1;
        r    = sbq.pop_front();
        check({name, " verified"}, 128'(write_back_to_L2_verified), 128'(r.wb));
        check({name, " ready"}, 128'(L3_ready), 128'(!r.wb));
        if (!r.wb) check({name, " rdata"}, L3_read_data, r.data);
      end
    end
    write_back_to_L3_request = 1'b0;
    read_from_L3_request     = 1'b0;
    mem_ack                  = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL %s timeout: no response within 200 cycles, required one", name);
      sbq.delete();
    end
    check({name, " hit_pulses"}, 128'(hc), 128'(exp_hit ? 1 : 0));
    check({name, " miss_pulses"}, 128'(mc), 128'(exp_hit ? 0 : 1));
    if (exp_lat != 0) check({name, " latency"}, 128'(lat), 128'(exp_lat));
    check({name, " mem_ops_left"}, 128'(memq.size()), 128'(0));
    memq.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_stats(input string name);
`ifdef L3_STATS_EN
    check({name, " hit_count"}, 128'(hit_count), 128'(exp_hits));
    check({name, " miss_count"}, 128'(miss_count), 128'(exp_misses));
`else
    check({name, " hit_count"}, 128'(hit_count), 128'(0));
    check({name, " miss_count"}, 128'(miss_count), 128'(0));
`endif
  endtask

  initial begin
    int vpulses, rpulses;
    bit seen;
    vecs[0] = mkv("cold_rd",  0, 32'h0000_1000, '0,     0, D_A5,   0, 1, 0, 32'h1000, D_A5,   0, '0, '0);
    vecs[1] = mkv("pid_hit",  0, 32'h4000_1000, '0,     1, D_A5,   2, 0, 0, '0, '0,            0, '0, '0);
    vecs[2] = mkv("wb_hit",   1, 32'h0000_1000, D_1234, 1, '0,     2, 0, 0, '0, '0,            0, '0, '0);
    vecs[3] = mkv("conflict", 0, 32'h0000_1400, '0,     0, D_5A,   0, 2, 1, 32'h1000, D_1234, 0, 32'h1400, D_5A);
    vecs[4] = mkv("refetch",  0, 32'h0000_1000, '0,     0, D_C3,   0, 1, 0, 32'h1000, D_C3,   0, '0, '0);
    vecs[5] = mkv("wb_cold",  1, 32'h0000_2010, D_DEAD, 0, '0,     2, 0, 0, '0, '0,            0, '0, '0);
    vecs[6] = mkv("wb_evict", 1, 32'h0000_3010, D_BEEF, 0, '0,     0, 1, 1, 32'h2010, D_DEAD, 0, '0, '0);
    vecs[7] = mkv("rd_wbline",0, 32'h0000_3010, '0,     1, D_BEEF, 2, 0, 0, '0, '0,            0, '0, '0);

    reset = 1'b1;
    read_from_L3_request = 1'b0; write_back_to_L3_request = 1'b0;
    cache_L3_memory_address = '0; L2_writeback_data = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst L3_ready", 128'(L3_ready), 128'(0));
    check("rst verified", 128'(write_back_to_L2_verified), 128'(0));
    check("rst hit_miss", 128'({L3_hit, L3_miss}), 128'(0));
    check("rst mem_req", 128'({mem_req, mem_we}), 128'(0));
    check("rst mem_addr", 128'(mem_addr), 128'(0));
    check("rst mem_wdata", mem_wdata, '0);
    check("rst read_data", L3_read_data, '0);
    check("rst counters", 128'({hit_count, miss_count}), 128'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      if (vecs[k].nmem > 0) memq.push_back(vecs[k].m0);
      if (vecs[k].nmem > 1) memq.push_back(vecs[k].m1);
      run_txn(vecs[k].name, vecs[k].wb, vecs[k].addr, vecs[k].wd, vecs[k].hit, vecs[k].rdata, vecs[k].lat);
    end
    check("read_data_held", L3_read_data, D_BEEF);
    check_stats("table");

    // Both requests together: write-back wins, and holding them yields one pulse only.
    sbq.push_back('{wb: 1'b1, data: '0});
    exp_misses++;
    @(negedge clk);
    cache_L3_memory_address = 32'h0000_4020; L2_writeback_data = D_7777;
    write_back_to_L3_request = 1'b1; read_from_L3_request = 1'b1;
    vpulses = 0; rpulses = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) service_mem("both");
      rpulses += int'(L3_ready);
      if (write_back_to_L2_verified) begin
        seen = 1; vpulses++;
        void'(sbq.pop_front());
      end
    end
    mem_ack = 1'b0;
    repeat (5) begin
      @(negedge clk);
      vpulses += int'(write_back_to_L2_verified);
      rpulses += int'(L3_ready);
      if (mem_req) service_mem("both_hold");
      mem_ack = 1'b0;
    end
    check("both verified_pulses", 128'(vpulses), 128'(1));
    check("both ready_pulses", 128'(rpulses), 128'(0));
    write_back_to_L3_request = 1'b0; read_from_L3_request = 1'b0;
    sbq.delete();
    repeat (3) @(negedge clk);
    run_txn("rd_after_both", 0, 32'h0000_4020, '0, 1, D_7777, 2);
    check_stats("both");

    // Reset while FILL holds mem_req: request must drop in the same cycle.
    @(negedge clk);
    cache_L3_memory_address = 32'h0000_5030; read_from_L3_request = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) seen = 1;
    end
    check("fill mem_req_seen", 128'(seen), 128'(1));
    check("fill mem_addr", 128'(mem_addr), 128'(32'h5030));
    reset = 1'b1;
    #1;
    check("rst_fill mem_req", 128'(mem_req), 128'(0));
    check("rst_fill ready", 128'(L3_ready), 128'(0));
    exp_hits = 0; exp_misses = 0;
    check_stats("rst_fill");
    @(negedge clk);
    read_from_L3_request = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    memq.push_back('{we: 1'b0, addr: 32'h3010, data: D_66});
    run_txn("reread_after_rst", 0, 32'h0000_3010, '0, 0, D_66, 0);
    run_txn("hit_after_rst", 0, 32'h8000_3010, '0, 1, D_66, 2);
    check_stats("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
